cla_serial_controller: RTL and testbench
========================================

CLA_SERIAL_CONTROLLER -- requirements
Module: cla_serial_controller

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the operand width in 4-bit slices (W = 4*NIBBLES).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A  input  W  operand A; captured on the accepted start.
REQ-006 SHALL have port B  input  W  operand B; captured on the accepted start.
REQ-007 SHALL have port cinput  input  1  carry-in; captured on the accepted start.
REQ-008 SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is complete.
REQ-010 SHALL have port Sum  output  W  result word.
REQ-011 SHALL have port Cout  output  1  carry out of the most significant nibble.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, capture A, B and cinput, set nibble index idx=0, clear Sum and Cout to 0, and go to RUN.
REQ-014 SHALL, in each RUN cycle, add A[idx], B[idx] and the carry register through the single 4-bit CLA slice, write Sum[idx], load the carry register from the slice carry-out, and increment idx.
REQ-015 SHALL, in the RUN cycle where idx=NIBBLES-1, load Cout from the slice carry-out and go to DONE.
REQ-016 SHALL, in DONE, assert done for exactly one cycle and return to IDLE on the next edge.
REQ-017 SHALL have a latency of NIBBLES+1 cycles from the accepting edge to the edge that presents done (5 cycles for NIBBLES=4).
REQ-018 SHALL ignore start while busy=1; captured operands SHALL NOT change during RUN.
REQ-019 SHALL hold Sum and Cout stable from done until the next accepted start.
REQ-020 SHALL accept the start cycle immediately after DONE (back-to-back operations allowed).
REQ-021 SHALL produce Sum and Cout equal to (A + B + cinput) mod 2^(W+1), split into Sum and Cout.
REQ-022 SHALL let idx wrap-around never occur: idx saturates and is reset on the next start.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-RUN, immediately force state=IDLE, idx=0, carry=0, Sum=0, Cout=0, done=0, busy=0.
REQ-024 SHALL accept a start in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL use the macro CLA_SERIAL_SUB_EN to compile subtraction in or out.
REQ-026 SHALL, when CLA_SERIAL_SUB_EN is defined, add an input port sub (1 bit, captured on start) under which B is inverted, cinput is ignored, the initial carry=1, and Cout=1 means no borrow.
REQ-027 SHALL, when CLA_SERIAL_SUB_EN is undefined, have no sub port and perform addition only.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/RUN/DONE) and the constant NIBBLE_W=4 in the shared package cla_pkg.
REQ-029 SHALL instantiate exactly one existing carry_look_ahead_adder as its datapath sub-module; all other logic SHALL be in the controller.

Verification (NIBBLES=4)
REQ-030 SHALL verify A=0xFFFF, B=0x0001, cinput=0 -> Sum=0x0000, Cout=1, done 5 cycles after the start.
REQ-031 SHALL verify A=0x1234, B=0x4321, cinput=1 -> Sum=0x5556, Cout=0; busy high for exactly 5 cycles.
REQ-032 SHALL verify a start pulse in the 2nd RUN cycle with A=0xAAAA -> ignored; the first result is unchanged and there is no extra done.
REQ-033 SHALL verify rst asserted in the 3rd RUN cycle -> all outputs 0 immediately; a new start with 0x0001+0x0001 -> Sum=0x0002.
REQ-034 SHALL verify, with CLA_SERIAL_SUB_EN defined, sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, Cout=0; A=0x0007, B=0x0005 -> Sum=0x0002, Cout=1.
REQ-035 SHALL verify a start in the cycle after done -> accepted, with the second result correct.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the serial carry-look-ahead controller.
package cla_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cla_serial_controller_if.sv
// Operand/result bus of the serial CLA controller.
// The sub signal exists only when CLA_SERIAL_SUB_EN is defined.
interface cla_serial_controller_if
  import cla_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
);

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cinput;
`ifdef CLA_SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;

`ifdef CLA_SERIAL_SUB_EN
  modport master (
    output start, A, B, cinput, sub,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, cinput, sub,
    output busy, done, Sum, Cout
  );
`else
  modport master (
    output start, A, B, cinput,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, cinput,
    output busy, done, Sum, Cout
  );
`endif

endinterface

// File: rtl/carry_look_ahead_adder.sv
// One 4-bit carry-look-ahead slice: all carries formed directly from generate/propagate.
module carry_look_ahead_adder
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_serial_controller.sv
// Nibble-serial adder: one CLA slice reused over NIBBLES cycles, result held until next start.
// Define CLA_SERIAL_SUB_EN to add the sub input (A - B, Cout=1 means no borrow).
module cla_serial_controller
  import cla_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  cla_serial_controller_if.slave bus
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          state_q;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
`ifdef CLA_SERIAL_SUB_EN
  logic            sub_q;
`endif

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_b_raw;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic                carry_init;

  assign slice_a     = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign slice_b_raw = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

`ifdef CLA_SERIAL_SUB_EN
  // Two's-complement subtract: invert B per slice and seed the carry with 1.
  assign slice_b    = sub_q ? ~slice_b_raw : slice_b_raw;
  assign carry_init = bus.sub ? 1'b1 : bus.cinput;
`else
  assign slice_b    = slice_b_raw;
  assign carry_init = bus.cinput;
`endif

  carry_look_ahead_adder u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_s),
    .cout (slice_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CLA_SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= carry_init;
`ifdef CLA_SERIAL_SUB_EN
            sub_q   <= bus.sub;
`endif
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry_q                            <= slice_co;
          // idx stops at the last nibble rather than wrapping.
          if (idx_q == IdxW'(NIBBLES - 1)) begin
            cout_q  <= slice_co;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

endmodule

// File: tb/tb_cla_serial_controller.sv
// Randomized bench for cla_serial_controller (NIBBLES=4) against an arithmetic model.
// Subtraction cases run only when CLA_SERIAL_SUB_EN is defined.
module tb_cla_serial_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cla_serial_controller_if #(.NIBBLES(4)) bus ();

  cla_serial_controller #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + {16'd0, ci};
  endfunction

  task automatic set_sub(input logic sb);
`ifdef CLA_SERIAL_SUB_EN
    bus.sub = sb;
`else
    if (sb) $display("note: sub requested without CLA_SERIAL_SUB_EN");
`endif
  endtask

  // Starts an operation from the current cycle, returns in the cycle where done is seen.
  // With poke set, a spurious start with A=AAAA is raised during the second RUN cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input bit poke);
    int          lat;
    int          bcnt;
    logic [16:0] exp;
    exp        = model(a, b, ci, sb);
    bus.A      = a;
    bus.B      = b;
    bus.cinput = ci;
    set_sub(sb);
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    // Scramble the bus inputs; the captured operands must not follow.
    bus.A      = 16'($urandom);
    bus.B      = 16'($urandom);
    bus.cinput = 1'($urandom);
    set_sub(1'($urandom));
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      if (poke && lat == 1) begin
        bus.A     = 16'hAAAA;
        bus.start = 1'b1;
      end
      if (poke && lat == 2) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check({tag, ":latency"}, lat, 5);
    check({tag, ":busy_cycles"}, bcnt, 5);
    check({tag, ":sum"}, {16'd0, bus.Sum}, {16'd0, exp[15:0]});
    check({tag, ":cout"}, {31'd0, bus.Cout}, {31'd0, exp[16]});
  endtask

  // One idle cycle after done: pulse must have ended, result held.
  task automatic idle_hold(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic sb);
    logic [16:0] exp;
    exp = model(a, b, ci, sb);
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, ":idle_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, ":sum_hold"}, {16'd0, bus.Sum}, {16'd0, exp[15:0]});
    check({tag, ":cout_hold"}, {31'd0, bus.Cout}, {31'd0, exp[16]});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        rs;
    int          extra;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.A      = '0;
    bus.B      = '0;
    bus.cinput = 1'b0;
    set_sub(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset:busy", {31'd0, bus.busy}, 32'd0);
    check("reset:done", {31'd0, bus.done}, 32'd0);
    check("reset:sum", {16'd0, bus.Sum}, 32'd0);
    check("reset:cout", {31'd0, bus.Cout}, 32'd0);
    rst = 1'b0;

    run_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_hold("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);

    run_op("1234_4321_c1", 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    idle_hold("1234_4321_c1", 16'h1234, 16'h4321, 1'b1, 1'b0);

    run_op("start_in_run", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) extra++;
    end
    check("start_in_run:extra_done", extra, 0);
    check("start_in_run:sum_kept", {16'd0, bus.Sum}, 32'h3333);

    run_op("b2b_first", 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
    run_op("b2b_second", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
    idle_hold("b2b_second", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    // Reset asserted during the third RUN cycle.
    bus.A      = 16'hFFFF;
    bus.B      = 16'hFFFF;
    bus.cinput = 1'b1;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_rst:busy", {31'd0, bus.busy}, 32'd0);
    check("midrun_rst:done", {31'd0, bus.done}, 32'd0);
    check("midrun_rst:sum", {16'd0, bus.Sum}, 32'd0);
    check("midrun_rst:cout", {31'd0, bus.Cout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_hold("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

`ifdef CLA_SERIAL_SUB_EN
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    idle_hold("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    idle_hold("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
`ifdef CLA_SERIAL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_hold($sformatf("rand%0d", i), ra, rb, rc, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
